// File: rtl/noise_sched.sv
// Round-robin scheduler that shares one free-running noise LFSR between N_REQ consumers.
// It owns the LFSR reset/reseed sequencing and keeps grants at least STRIDE cycles apart.
module noise_sched #(
    parameter int N_REQ    = 4,
    parameter int SAMPLE_W = 16,
    parameter int STRIDE   = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                enable_in,
    input  logic                reseed_in,
    input  logic [30:0]         lfsr_in,
    output logic                lfsr_rst_out,
    input  logic [N_REQ-1:0]    req_in,
    output logic [N_REQ-1:0]    grant_out,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid_out
);

    localparam int CNT_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STRIDE - 1);

    typedef enum logic {WARM, READY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] ptr;

    logic             found;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W:0]   idx;

    // Search upward from ptr with wrap-around; the first set request wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(N_REQ))
                idx = idx - (PTR_W+1)'(N_REQ);
            if (!found && req_in[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
        ptr_next = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            lfsr_rst_out     <= 1'b1;
            grant_out        <= '0;
            sample_valid_out <= 1'b0;
            sample_out       <= '0;
            ptr              <= '0;
            cnt              <= CNT_RELOAD;
            state            <= WARM;
        end else begin
            lfsr_rst_out     <= 1'b0;
            grant_out        <= '0;
            sample_valid_out <= 1'b0;
            if (cnt != '0)
                cnt <= cnt - CNT_W'(1);

            // Reseed wins over a grant on the same edge and restarts the warm-up window.
            if (reseed_in) begin
                lfsr_rst_out <= 1'b1;
                cnt          <= CNT_RELOAD;
                state        <= WARM;
            end else begin
                case (state)
                    WARM: begin
                        if (cnt <= CNT_W'(1))
                            state <= READY;
                    end
                    READY: begin
                        if (enable_in && found) begin
                            grant_out        <= N_REQ'(1) << winner;
                            sample_out       <= lfsr_in[30 -: SAMPLE_W];
                            sample_valid_out <= 1'b1;
                            ptr              <= ptr_next;
                            cnt              <= CNT_RELOAD;
                            state            <= WARM;
                        end
                    end
                    default: state <= WARM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noise_sched.sv
// Directed bench for noise_sched: drives a local 31-bit LFSR from lfsr_rst_out and
// checks grant order, spacing, samples, reseed, enable gating and mid-run reset.
module tb_noise_sched;

    localparam int N_REQ    = 4;
    localparam int SAMPLE_W = 16;
    localparam int STRIDE   = 16;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic                enable_in;
    logic                reseed_in;
    logic [30:0]         lfsr_in;
    logic                lfsr_rst_out;
    logic [N_REQ-1:0]    req_in;
    logic [N_REQ-1:0]    grant_out;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid_out;

    int checks = 0;
    int errors = 0;

    noise_sched #(.N_REQ(N_REQ), .SAMPLE_W(SAMPLE_W), .STRIDE(STRIDE)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .reseed_in        (reseed_in),
        .lfsr_in          (lfsr_in),
        .lfsr_rst_out     (lfsr_rst_out),
        .req_in           (req_in),
        .grant_out        (grant_out),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [30:0] lfsr_step(input logic [30:0] s);
        return {s[0] ^ s[3], s[30:1]};
    endfunction

    function automatic logic [SAMPLE_W-1:0] lfsr_after(input int n);
        logic [30:0] s;
        s = '1;
        repeat (n) s = lfsr_step(s);
        return s[30 -: SAMPLE_W];
    endfunction

    // Noise source the scheduler controls: held at the all-ones seed while reset is high.
    initial lfsr_in = '1;
    always @(posedge clk_in)
        lfsr_in <= lfsr_rst_out ? '1 : lfsr_step(lfsr_in);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_grant(input int max_cycles, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sample_valid_out && n < max_cycles);
        if (!sample_valid_out)
            check("grant_timeout", 32'(n), 32'(max_cycles + 1));
    endtask

    // Any grant activity must be a single one-hot bit coincident with the valid strobe.
    always @(negedge clk_in)
        if (grant_out != '0 || sample_valid_out)
            check("grant_onehot", {30'd0, sample_valid_out, $onehot(grant_out)}, 32'd3);

    initial begin
        int n;
        int stray;
        logic [N_REQ-1:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_in = 1'b0; enable_in = 1'b1; reseed_in = 1'b0; req_in = '0;
        repeat (3) tick();
        check("rst_lfsr_rst", lfsr_rst_out, 1);
        check("rst_grant", grant_out, 0);
        check("rst_valid", sample_valid_out, 0);
        check("rst_sample", sample_out, 0);

        // Warm-up after reset release: first grant at edge 15, next at edge 31.
        req_in = 4'b0001; rst_in = 1'b1;
        tick();
        check("lfsr_rst_fall", lfsr_rst_out, 0);
        wait_grant(40, n);
        check("first_latency", n, 15);
        check("first_grant", grant_out, 4'b0001);
        check("first_sample", sample_out, lfsr_after(14));
        tick();
        check("valid_drop", sample_valid_out, 0);
        check("grant_drop", grant_out, 0);
        check("sample_hold", sample_out, lfsr_after(14));
        wait_grant(40, n);
        check("second_latency", n, 15);
        check("second_sample", sample_out, lfsr_after(30));

        // All requesters held: rotation starting from ptr 0, exactly STRIDE apart.
        rst_in = 1'b0;
        tick();
        check("rst2_lfsr_rst", lfsr_rst_out, 1);
        req_in = 4'b1111; rst_in = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            wait_grant(40, n);
            check($sformatf("rr_gap%0d", i), n, (i == 0) ? 15 : 16);
            check($sformatf("rr_grant%0d", i), grant_out, order[i]);
        end

        // Wrap-around: reach ptr=2, then 0011 gives 0001 followed by 0010.
        req_in = 4'b0010;
        wait_grant(40, n);
        check("ptr2_gap", n, 16);
        check("ptr2_grant", grant_out, 4'b0010);
        req_in = 4'b0011;
        wait_grant(40, n);
        check("wrap_grant", grant_out, 4'b0001);
        wait_grant(40, n);
        check("wrap_next_gap", n, 16);
        check("wrap_next_grant", grant_out, 4'b0010);

        // Reseed on the edge where a grant would otherwise be issued.
        req_in = 4'b0100;
        stray = 0;
        repeat (15) begin
            tick();
            if (sample_valid_out) stray++;
        end
        check("pre_reseed_grants", stray, 0);
        reseed_in = 1'b1;
        tick();
        reseed_in = 1'b0;
        check("reseed_grant", grant_out, 0);
        check("reseed_valid", sample_valid_out, 0);
        check("reseed_lfsr_rst", lfsr_rst_out, 1);
        tick();
        check("reseed_lfsr_fall", lfsr_rst_out, 0);
        wait_grant(40, n);
        check("reseed_gap", n, 15);
        check("reseed_grant_after", grant_out, 4'b0100);
        check("reseed_sample", sample_out, lfsr_after(14));

        // Enable held low for 40 cycles blocks grants; grant follows enable by one edge.
        enable_in = 1'b0; req_in = 4'b1000;
        stray = 0;
        repeat (40) begin
            tick();
            if (sample_valid_out) stray++;
        end
        check("disabled_grants", stray, 0);
        enable_in = 1'b1;
        wait_grant(40, n);
        check("enable_latency", n, 1);
        check("enable_grant", grant_out, 4'b1000);

        // Leave ptr at 1, then reset on the edge a grant is due.
        req_in = 4'b0001;
        wait_grant(40, n);
        check("pre_rst_grant", grant_out, 4'b0001);
        req_in = 4'b1111;
        repeat (15) tick();
        rst_in = 1'b0;
        tick();
        check("midrst_grant", grant_out, 0);
        check("midrst_valid", sample_valid_out, 0);
        check("midrst_sample", sample_out, 0);
        check("midrst_lfsr_rst", lfsr_rst_out, 1);
        rst_in = 1'b1;
        wait_grant(40, n);
        check("midrst_warm", n, 16);
        check("midrst_ptr0", grant_out, 4'b0001);
        check("midrst_sample2", sample_out, lfsr_after(14));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noise_sched.md
Name: noise_sched

Overview:
- Shares the single free-running 31-bit maximal-length noise LFSR between N_REQ consumers, e.g. per-voice unvoiced-excitation generators in the vocoder.
- Owns the LFSR's reset and reseed sequencing.
- Enforces a minimum spacing of STRIDE cycles between grants, so successive samples come from non-overlapping shift windows.
- Round-robin arbitration decides which consumer receives each sample.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SAMPLE_W, 16, width of the sample delivered per grant (1..31).
- STRIDE, 16, minimum cycles between consecutive grants; must satisfy SAMPLE_W <= STRIDE <= 255.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-low reset.
- enable_in  input  1  arbitration enable; when low, no grants are issued and the spacing counter keeps running.
- reseed_in  input  1  one-cycle pulse that restarts the LFSR from its seed.
- lfsr_in  input  31  current LFSR state word.
- lfsr_rst_out  output  1  active-high reset driven to the LFSR.
- req_in  input  N_REQ  per-requester level request; held until granted.
- grant_out  output  N_REQ  one-hot grant, one-cycle pulse.
- sample_out  output  SAMPLE_W  noise sample, valid with sample_valid_out.
- sample_valid_out  output  1  one-cycle strobe, coincident with grant_out.

Behaviour:
- All state is registered and updated on the clk_in rising edge.
- Reset (rst_in low):
  - lfsr_rst_out=1, grant_out=0, sample_valid_out=0, sample_out=0.
  - Round-robin pointer ptr=0, spacing counter cnt=STRIDE-1, state=WARM.
- lfsr_rst_out: first edge with rst_in high clears it; it rises again for exactly one cycle on each reseed.
- Spacing counter cnt, width ceil(log2(STRIDE)):
  - Decrements by 1 per cycle while nonzero and saturates at 0.
  - Reloaded to STRIDE-1 on every grant and every reseed.
- FSM:
  - WARM: cnt!=0, grants blocked. Moves to READY on the edge where cnt reaches 0. This guarantees the seed word (all ones) is never delivered.
  - READY: cnt==0. On an edge with enable_in=1 and req_in!=0, issue a grant and move to WARM (cnt=STRIDE-1). Otherwise stay in READY.
- Grant at the edge:
  - Winner = first set bit of req_in, searching upward from ptr with wrap-around.
  - grant_out <= onehot(winner).
  - sample_out <= lfsr_in[30 -: SAMPLE_W], sampled on that same edge.
  - sample_valid_out <= 1.
  - ptr <= (winner+1) mod N_REQ.
  - grant_out and sample_valid_out drop on the next edge; sample_out holds its value until the next grant.
- Latency: 1 cycle from the sampled req_in/cnt==0 to grant_out high.
- Spacing: grants at edges t and t' satisfy t'-t >= STRIDE. With continuous requests, t'-t == STRIDE exactly.
- Fairness: a continuously held request is granted within N_REQ grants, i.e. at most N_REQ*STRIDE cycles once READY with enable_in=1.
- Reseed: reseed_in=1 at an edge gives lfsr_rst_out<=1 for that one cycle, cnt<=STRIDE-1, state<=WARM.
  - Reseed has priority over a grant on the same edge; no grant is issued.
  - ptr is unchanged.
- enable_in low in READY: stays in READY with no grant. The grant occurs on the first edge with enable_in high and a request.
- req_in dropped before a grant: no grant, no error. A req_in bit deasserted on the grant edge itself is still granted, since the value at the edge is what is sampled.
- Reset mid-operation (rst_in low at any edge): all outputs go to reset values immediately at that edge; any pending grant is discarded.
- Arbitration never issues more than one grant bit per cycle; grant_out==0 whenever sample_valid_out==0.

Test Plan:
- Reset release, req_in=4'b0001 held, enable_in=1: lfsr_rst_out falls at edge 0; first grant at edge STRIDE-1=15 with sample_out = bits[30:15] of lfsr_in at that edge (not 16'hFFFF); next grant at edge 31.
- req_in=4'b1111 held continuously: grant order 0001, 0010, 0100, 1000, 0001, with grants exactly 16 cycles apart; sample_valid_out is high for 1 cycle each.
- ptr=2, req_in=4'b0011: grant 0001 (wrap-around); ptr becomes 1; the next grant is 0010.
- reseed_in pulsed on the same edge cnt==0 with req_in=4'b0100: no grant that cycle; lfsr_rst_out high for 1 cycle; the next grant is 16 cycles later, and its sample matches a fresh LFSR stepped the same number of cycles from reset.
- enable_in=0 for 40 cycles with req_in=4'b1000: no grants; enable_in rises and grant 1000 follows 1 cycle later.
- rst_in pulled low on the cycle before a due grant: grant_out and sample_valid_out stay 0, sample_out=0, ptr=0, and warm-up restarts.
